// File: rtl/mdu_issue_ctrl.sv
// ----------------------------------------------------------------------------
// mdu_issue_ctrl
//   Initiator side of the E-stage MDU start/busy interface. It drives
//   mdu_start/mdu_op from the E-stage instruction. Each mult/multu/div/divu is
//   issued exactly once, even if E is held. D-stage MDU instructions are
//   stalled while an operation is in flight. The block also tracks the
//   expected busy window and records any deviation by the MDU in a sticky
//   error flag.
//
// Handshake: a start is a single-cycle pulse on mdu_start_o while the block
//   is IDLE. The MDU must raise busy on the cycle after the start. It must
//   keep busy high for exactly the op latency, then drop it. The block sees
//   no busy from the MDU during its own start cycle. For that reason stall_d_o
//   also covers the start cycle.
//
// Ports
//   clk          in   clock
//   reset        in   synchronous, active-high reset
//   d_mdu_use_i  in   D-stage instruction is any MDU op
//   e_valid_i    in   E stage holds a real (non-bubble) instruction
//   e_op_i       in   [3:0] E-stage MDU op (0..7 valid, else none)
//   e_hold_i     in   E frozen this cycle, same instruction next cycle
//   e_flush_i    in   E instruction squashed this cycle
//   mdu_busy_i   in   MDU busy flag
//   mdu_start_o  out  start pulse to MDU
//   mdu_op_o     out  [3:0] op to MDU (OP_NONE when E has no MDU op)
//   stall_d_o    out  freeze F/D and insert a bubble into E
//   busy_left_o  out  [3:0] remaining expected busy cycles (debug view of FSM)
//   proto_err_o  out  sticky: MDU busy window did not match expectation
// ----------------------------------------------------------------------------
module mdu_issue_ctrl #(
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10,
    parameter logic [3:0]  OP_NONE  = 4'b1111
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       d_mdu_use_i,
    input  logic       e_valid_i,
    input  logic [3:0] e_op_i,
    input  logic       e_hold_i,
    input  logic       e_flush_i,
    input  logic       mdu_busy_i,
    output logic       mdu_start_o,
    output logic [3:0] mdu_op_o,
    output logic       stall_d_o,
    output logic [3:0] busy_left_o,
    output logic       proto_err_o
);

    localparam logic [3:0] MULT_LAT_W = 4'(MULT_LAT);
    localparam logic [3:0] DIV_LAT_W  = 4'(DIV_LAT);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       issued_q, issued_d;
    logic       err_q, err_d;

    logic       e_live;
    logic       is_md;
    logic [3:0] lat;
    logic       start;

    // A flushed instruction or a bubble must never reach the MDU.
    // This applies even to mthi/mtlo.
    assign e_live = e_valid_i & ~e_flush_i;
    assign is_md  = (e_op_i[3:2] == 2'b00);
    assign lat    = e_op_i[1] ? DIV_LAT_W : MULT_LAT_W;

    // The start pulse is suppressed during reset, because the MDU is being
    // reset in the same cycle.
    assign start = ~reset & e_live & is_md & ~issued_q & (state_q == IDLE);

    assign mdu_start_o = start;
    assign mdu_op_o    = (e_live && !e_op_i[3]) ? e_op_i : OP_NONE;
    assign stall_d_o   = d_mdu_use_i & (start | (state_q == BUSY));
    assign busy_left_o = (state_q == BUSY) ? cnt_q : 4'd0;
    assign proto_err_o = err_q;

    // The FSM and the busy-window check.
    // In IDLE the MDU must not be busy. A start always moves the FSM to
    // BUSY, so "busy without a start in the previous cycle" is the same as
    // "busy while IDLE". The same test also covers the first IDLE cycle
    // after a window.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (mdu_busy_i) begin
                    err_d = 1'b1;
                end
                if (start) begin
                    state_d = BUSY;
                    cnt_d   = lat;
                end
            end
            BUSY: begin
                if (!mdu_busy_i) begin
                    err_d = 1'b1;
                end
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // The issued flag remembers that the held E instruction was already
    // started. Once E advances or the instruction is flushed, the flag is
    // cleared so the next instruction can start.
    always_comb begin
        issued_d = issued_q;
        if (start && e_hold_i) begin
            issued_d = 1'b1;
        end else if (!e_hold_i || e_flush_i) begin
            issued_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            issued_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            issued_q <= issued_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
module tb_mdu_issue_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       d_mdu_use, e_valid, e_hold, e_flush, mdu_busy;
  logic [3:0] e_op;
  logic       mdu_start;
  logic [3:0] mdu_op;
  logic       stall_d;
  logic [3:0] busy_left;
  logic       proto_err;

  always #5 clk = ~clk;

  mdu_issue_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .d_mdu_use_i (d_mdu_use),
    .e_valid_i   (e_valid),
    .e_op_i      (e_op),
    .e_hold_i    (e_hold),
    .e_flush_i   (e_flush),
    .mdu_busy_i  (mdu_busy),
    .mdu_start_o (mdu_start),
    .mdu_op_o    (mdu_op),
    .stall_d_o   (stall_d),
    .busy_left_o (busy_left),
    .proto_err_o (proto_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model, kept in cycle-number terms: the last start time and
  // its latency define the required busy window t+1 .. t+lat.
  int cyc     = 0;
  int t_start = -100;
  int m_lat   = 0;
  bit m_err   = 0;
  bit m_started_cur = 0;

  // MDU stimulus model: counts down the busy cycles it will drive. mdu_adj
  // shortens or lengthens its window to provoke protocol errors.
  int mdu_rem = 0;
  int mdu_adj = 0;

  // Values observed in the most recent step, for literal checks.
  logic       obs_start, obs_stall, obs_err;
  logic [3:0] obs_op, obs_left;

  function automatic int lat_of(input logic [3:0] op);
    return op[1] ? 10 : 5;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle. Inputs are driven at the negedge, and the outputs are
  // compared against the model 1ns later. Model state is then advanced as
  // of the next posedge.
  task automatic step(input bit rst, input bit dv, input logic [3:0] op, input bit hold,
                      input bit flush, input bit duse, input bit flip_busy);
    bit in_flight, exp_start, exp_stall;
    int exp_left;
    logic [3:0] exp_op;
    @(negedge clk);
    reset     = rst;
    e_valid   = dv;
    e_op      = op;
    e_hold    = hold;
    e_flush   = flush;
    d_mdu_use = duse;
    mdu_busy  = (mdu_rem > 0) ^ flip_busy;
    #1;
    in_flight = (cyc >= t_start + 1) && (cyc <= t_start + m_lat);
    exp_start = !rst && dv && !flush && (op <= 3) && !m_started_cur && !in_flight;
    exp_op    = (dv && !flush && op <= 7) ? op : 4'hF;
    exp_stall = duse && (exp_start || in_flight);
    exp_left  = in_flight ? (t_start + m_lat - cyc + 1) : 0;
    obs_start = mdu_start;
    obs_stall = stall_d;
    obs_err   = proto_err;
    obs_op    = mdu_op;
    obs_left  = busy_left;
    chk("mdu_start", 32'(mdu_start), 32'(exp_start));
    chk("mdu_op", 32'(mdu_op), 32'(exp_op));
    chk("stall_d", 32'(stall_d), 32'(exp_stall));
    chk("busy_left", 32'(busy_left), 32'(exp_left));
    chk("proto_err", 32'(proto_err), 32'(m_err));
    // The MDU stimulus reacts to the start actually driven by the DUT.
    if (rst) begin
      mdu_rem = 0;
    end else begin
      if (mdu_rem > 0) mdu_rem--;
      if (mdu_start) mdu_rem = lat_of(op) + mdu_adj;
    end
    // Advance the model.
    if (rst) begin
      t_start = -100;
      m_lat = 0;
      m_err = 0;
      m_started_cur = 0;
    end else begin
      if (mdu_busy != in_flight) m_err = 1;
      if (exp_start) begin
        t_start = cyc;
        m_lat = lat_of(op);
      end
      if (exp_start && hold) m_started_cur = 1;
      else if (!hold || flush) m_started_cur = 0;
    end
    cyc++;
  endtask

  task automatic bubble(input bit duse);
    step(0, 0, 4'hF, 0, 0, duse, 0);
  endtask

  task automatic do_reset();
    step(1, 0, 4'hF, 0, 0, 0, 0);
    step(1, 0, 4'hF, 0, 0, 0, 0);
  endtask

  initial begin
    int starts, busy_cycles;
    bit cur_dv, prev_hold, hold, flush;
    logic [3:0] cur_op;
    reset = 1; e_valid = 0; e_op = 4'hF; e_hold = 0; e_flush = 0;
    d_mdu_use = 0; mdu_busy = 0;

    // Reset state.
    do_reset();
    bubble(0);
    chk("rst_left", 32'(obs_left), 32'd0);
    chk("rst_err", 32'(obs_err), 32'd0);
    chk("rst_start", 32'(obs_start), 32'd0);

    // mult with no hold: one start, busy_left runs 5..1, and a following
    // mflo is stalled for 6 cycles.
    step(0, 1, 4'd0, 0, 0, 1, 0);
    chk("mult_start", 32'(obs_start), 32'd1);
    chk("mult_stall0", 32'(obs_stall), 32'd1);
    for (int i = 5; i >= 1; i--) begin
      bubble(1);
      chk("mult_left", 32'(obs_left), 32'(i));
      chk("mult_stall", 32'(obs_stall), 32'd1);
    end
    bubble(1);
    chk("mult_done_left", 32'(obs_left), 32'd0);
    chk("mult_done_stall", 32'(obs_stall), 32'd0);
    chk("mult_err", 32'(obs_err), 32'd0);

    // divu held in E for 4 cycles: exactly one start and 10 busy cycles.
    starts = 0; busy_cycles = 0;
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 4'd3, (i < 4), 0, 0, 0);
      starts += int'(obs_start);
      if (obs_left != 0) busy_cycles++;
    end
    for (int i = 0; i < 8; i++) begin
      bubble(0);
      starts += int'(obs_start);
      if (obs_left != 0) busy_cycles++;
    end
    chk("divu_starts", 32'(starts), 32'd1);
    chk("divu_busy_cycles", 32'(busy_cycles), 32'd10);
    chk("divu_idle", 32'(obs_left), 32'd0);

    // mult, then add, add and mfhi in D: adds pass, mfhi stalls, and the
    // bubbles carry OP_NONE.
    step(0, 1, 4'd1, 0, 0, 0, 0);
    step(0, 1, 4'hA, 0, 0, 0, 0);
    chk("add_nostall", 32'(obs_stall), 32'd0);
    step(0, 1, 4'hA, 0, 0, 1, 0);
    chk("mfhi_stall", 32'(obs_stall), 32'd1);
    chk("add_op_none", 32'(obs_op), 32'hF);
    for (int i = 0; i < 3; i++) begin
      bubble(1);
      chk("bubble_op", 32'(obs_op), 32'hF);
    end
    bubble(1);
    chk("mfhi_released", 32'(obs_stall), 32'd0);

    // The MDU drops busy after 3 of 5 cycles. proto_err is set and then
    // held until reset.
    mdu_adj = -2;
    step(0, 1, 4'd0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) bubble(0);
    mdu_adj = 0;
    chk("short_busy_err", 32'(obs_err), 32'd1);
    for (int i = 0; i < 4; i++) bubble(0);
    chk("err_sticky", 32'(obs_err), 32'd1);
    do_reset();
    bubble(0);
    chk("err_cleared", 32'(obs_err), 32'd0);

    // Reset in the middle of a div, at busy_left=7.
    step(0, 1, 4'd2, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) bubble(1);
    step(1, 1, 4'd0, 0, 0, 1, 0);
    chk("div_left7", 32'(obs_left), 32'd7);
    chk("rst_cycle_nostart", 32'(obs_start), 32'd0);
    step(0, 0, 4'hF, 0, 0, 1, 0);
    chk("post_rst_left", 32'(obs_left), 32'd0);
    chk("post_rst_stall", 32'(obs_stall), 32'd0);
    chk("post_rst_err", 32'(obs_err), 32'd0);
    chk("post_rst_start", 32'(obs_start), 32'd0);

    // A div in E that is flushed must not start.
    step(0, 1, 4'd2, 0, 1, 0, 0);
    chk("flush_start", 32'(obs_start), 32'd0);
    chk("flush_op", 32'(obs_op), 32'hF);
    bubble(0);
    chk("flush_idle", 32'(obs_left), 32'd0);

    // Random traffic against the model.
    prev_hold = 0; cur_dv = 0; cur_op = 4'hF;
    for (int i = 0; i < 3000; i++) begin
      bit rst, duse, flip;
      rst = ($urandom_range(99, 0) < 2);
      if (!prev_hold) begin
        cur_dv = ($urandom_range(99, 0) < 80);
        cur_op = ($urandom_range(1, 0) == 1) ? 4'($urandom_range(3, 0))
                                             : 4'($urandom_range(15, 0));
      end
      hold  = ($urandom_range(99, 0) < 30);
      flush = !hold && ($urandom_range(99, 0) < 10);
      duse  = $urandom_range(1, 0) == 1;
      flip  = ($urandom_range(999, 0) < 5);
      case ($urandom_range(19, 0))
        0: mdu_adj = -int'($urandom_range(3, 1));
        1: mdu_adj = 1;
        default: mdu_adj = 0;
      endcase
      step(rst, cur_dv, cur_op, hold, flush, duse, flip);
      prev_hold = hold && !rst;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
